// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 8x8 LED matrix arbiter.
// Row r is driven by pulling hang bit (7-r) low.
package led_matrix_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam int         ROWS      = 8;
   localparam int         ROW_W     = 3;
   localparam logic [7:0] HANG_IDLE = 8'hFF;
   localparam logic [7:0] GRE_BLANK = 8'h00;

   function automatic logic [7:0] row_sel(input logic [ROW_W-1:0] row);
      return ~(8'h80 >> row);
   endfunction

endpackage

// File: rtl/matrix_row_scanner.sv
// Row/column timing for the matrix: holds each row SCAN_DIV cycles and flags
// the last cycle of row 7. row_nxt is the row shown in the following cycle.
module matrix_row_scanner
   import led_matrix_pkg::*;
#(
   parameter int SCAN_DIV = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scan_en,
   input  logic             scan_active,
   output logic [ROW_W-1:0] row_nxt,
   output logic             frame_done
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_nxt;
   logic [ROW_W-1:0] row_q;

   // A fresh grant (scan_en while not yet active) starts from row 0, div 0.
   always_comb begin
      row_nxt = '0;
      div_nxt = '0;
      if (scan_en && scan_active) begin
         if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            row_nxt = row_q + 1'b1;
         end else begin
            row_nxt = row_q;
            div_nxt = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q      <= '0;
         div_q      <= '0;
         frame_done <= 1'b0;
      end else begin
         row_q      <= row_nxt;
         div_q      <= div_nxt;
         frame_done <= (row_nxt == ROW_W'(ROWS - 1)) && (div_nxt == DIV_W'(SCAN_DIV - 1));
      end
   end

endmodule

// File: rtl/led_matrix_arbiter.sv
// Shares one 8x8 LED matrix and beeper among N_REQ screen sources, switching
// owner only at frame boundaries. Define LED_MATRIX_ARB_ROUND_ROBIN_EN for round-robin.
module led_matrix_arbiter
   import led_matrix_pkg::*;
#(
   parameter int N_REQ      = 3,
   parameter int SCAN_DIV   = 16,
   parameter int MIN_FRAMES = 4,
   parameter int BEEP_DIV   = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [64*N_REQ-1:0] bitmap,
   input  logic [N_REQ-1:0]    beep_req,
   output logic [N_REQ-1:0]    grant,
   output logic [7:0]          hang,
   output logic [7:0]          gre,
   output logic                beep,
   output logic                frame_done
);

   localparam int OW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int FC_W = $clog2(MIN_FRAMES + 1);
   localparam int BC_W = $clog2(BEEP_DIV + 1);

   state_e           state_q, state_nxt;
   logic [OW-1:0]    owner_q, owner_nxt, win_idx;
   logic [N_REQ-1:0] grant_nxt;
   logic [FC_W-1:0]  fcnt_q, fcnt_nxt, fcnt_inc;
   logic             dropped_q, dropped_nxt;
   logic [BC_W-1:0]  bcnt_q, bcnt_nxt;
   logic             beep_nxt, change, scan_en;
   logic [7:0]       hang_nxt, gre_nxt;
   logic [ROW_W-1:0] row_nxt;
   logic [7:0]       src_row [N_REQ][ROWS];

   for (genvar i = 0; i < N_REQ; i++) begin : g_src
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         assign src_row[i][r] = bitmap[64*i + 8*r +: 8];
      end
   end

`ifdef LED_MATRIX_ARB_ROUND_ROBIN_EN
   logic [OW-1:0] last_q;

   // Search upward from last+1 with wrap; last itself is checked last.
   function automatic logic [OW-1:0] pick(input logic [N_REQ-1:0] r, input logic [OW-1:0] last);
      int idx;
      pick = last;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = (int'(last) + k) % N_REQ;
         if (r[idx]) pick = OW'(idx);
      end
   endfunction

   assign win_idx = pick(req, last_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= OW'(N_REQ - 1);
      else if (change && state_nxt == SCAN) last_q <= owner_nxt;
   end
`else
   function automatic logic [OW-1:0] pick(input logic [N_REQ-1:0] r);
      pick = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (r[i]) pick = OW'(i);
      end
   endfunction

   assign win_idx = pick(req);
`endif

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt   = state_q;
      owner_nxt   = owner_q;
      grant_nxt   = grant;
      fcnt_nxt    = fcnt_q;
      fcnt_inc    = fcnt_q;
      dropped_nxt = dropped_q;
      change      = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_nxt   = SCAN;
               owner_nxt   = win_idx;
               grant_nxt   = N_REQ'(1) << win_idx;
               fcnt_nxt    = '0;
               dropped_nxt = 1'b0;
               change      = 1'b1;
            end
         end
         SCAN: begin
            if (!req[owner_q]) dropped_nxt = 1'b1;
            if (frame_done) begin
               fcnt_inc    = (fcnt_q == FC_W'(MIN_FRAMES)) ? fcnt_q : fcnt_q + 1'b1;
               fcnt_nxt    = fcnt_inc;
               dropped_nxt = 1'b0;
               if (fcnt_inc == FC_W'(MIN_FRAMES) || !req[owner_q]) begin
                  if (!(|req)) begin
                     state_nxt = IDLE;
                     grant_nxt = '0;
                     fcnt_nxt  = '0;
                     change    = 1'b1;
                  end else if (win_idx != owner_q) begin
                     owner_nxt = win_idx;
                     grant_nxt = N_REQ'(1) << win_idx;
                     fcnt_nxt  = '0;
                     change    = 1'b1;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign scan_en = (state_nxt == SCAN);

   matrix_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
      .clk         (clk),
      .rst         (rst),
      .scan_en     (scan_en),
      .scan_active (state_q == SCAN),
      .row_nxt     (row_nxt),
      .frame_done  (frame_done)
   );

   // Outputs are computed for the next cycle so the registered pins line up with the row.
   always_comb begin
      hang_nxt = HANG_IDLE;
      gre_nxt  = GRE_BLANK;
      bcnt_nxt = '0;
      beep_nxt = 1'b0;
      if (scan_en) begin
         hang_nxt = row_sel(row_nxt);
         if (!dropped_nxt) gre_nxt = src_row[owner_nxt][row_nxt];
      end
      if (state_q == SCAN && scan_en && !change && beep_req[owner_q]) begin
         if (bcnt_q == BC_W'(BEEP_DIV)) begin
            beep_nxt = ~beep;
         end else begin
            bcnt_nxt = bcnt_q + 1'b1;
            beep_nxt = beep;
         end
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         grant     <= '0;
         fcnt_q    <= '0;
         dropped_q <= 1'b0;
         bcnt_q    <= '0;
         beep      <= 1'b0;
         hang      <= HANG_IDLE;
         gre       <= GRE_BLANK;
      end else begin
         state_q   <= state_nxt;
         owner_q   <= owner_nxt;
         grant     <= grant_nxt;
         fcnt_q    <= fcnt_nxt;
         dropped_q <= dropped_nxt;
         bcnt_q    <= bcnt_nxt;
         beep      <= beep_nxt;
         hang      <= hang_nxt;
         gre       <= gre_nxt;
      end
   end

endmodule

// File: tb/tb_led_matrix_arbiter.sv
// Self-checking bench for led_matrix_arbiter: directed steps plus random traffic
// compared every cycle against a frame-position reference model.
module tb_led_matrix_arbiter;

   localparam int N     = 3;
   localparam int SD    = 16;
   localparam int MF    = 4;
   localparam int BD    = 10;
   localparam int FRAME = 8 * SD;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, beep_req;
   logic [64*N-1:0] bitmap;
   logic [N-1:0]   grant;
   logic [7:0]     hang, gre;
   logic           beep, frame_done;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   led_matrix_arbiter #(
      .N_REQ(N), .SCAN_DIV(SD), .MIN_FRAMES(MF), .BEEP_DIV(BD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .bitmap     (bitmap),
      .beep_req   (beep_req),
      .grant      (grant),
      .hang       (hang),
      .gre        (gre),
      .beep       (beep),
      .frame_done (frame_done)
   );

   // Reference model state, describing the current cycle.
   bit         m_scan;
   int         m_owner, m_pos, m_frames, m_brun, m_last;
   bit         m_drop;
   logic [7:0] m_gre;
   logic       m_beep;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(input logic [N-1:0] r);
      int w;
      w = -1;
`ifdef LED_MATRIX_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++)
         if (w < 0 && r[(m_last + k) % N]) w = (m_last + k) % N;
`else
      for (int i = 0; i < N; i++)
         if (w < 0 && r[i]) w = i;
`endif
      return w;
   endfunction

   task automatic model_reset();
      m_scan = 0; m_owner = 0; m_pos = 0; m_frames = 0; m_brun = 0;
      m_drop = 0; m_gre = 8'h00; m_beep = 1'b0; m_last = N - 1;
   endtask

   // Advance the model by one clock using the inputs present in this cycle.
   task automatic model_step();
      bit n_scan, n_drop, change;
      int n_owner, n_pos, frames, w;
      n_scan = m_scan; n_owner = m_owner; n_pos = m_pos; frames = m_frames;
      n_drop = m_drop; change = 0;
      if (!m_scan) begin
         if (req != '0) begin
            n_scan = 1; n_owner = winner(req); n_pos = 0; frames = 0; n_drop = 0; change = 1;
         end
      end else begin
         n_drop = m_drop || !req[m_owner];
         if (m_pos == FRAME - 1) begin
            n_pos  = 0;
            frames = m_frames + 1;
            n_drop = 0;
            if (frames >= MF || !req[m_owner]) begin
               if (req == '0) begin
                  n_scan = 0; change = 1;
               end else begin
                  w = winner(req);
                  if (w != m_owner) begin
                     n_owner = w; frames = 0; change = 1;
                  end
               end
            end
         end else begin
            n_pos = m_pos + 1;
         end
      end
      if (m_scan && n_scan && !change && beep_req[m_owner]) m_brun++;
      else m_brun = 0;
      m_beep = ((m_brun / (BD + 1)) % 2) == 1;
      m_gre  = (n_scan && !n_drop) ? bitmap[n_owner*64 + (n_pos/SD)*8 +: 8] : 8'h00;
      if (change && n_scan) m_last = n_owner;
      m_scan = n_scan; m_owner = n_owner; m_pos = n_pos; m_frames = frames; m_drop = n_drop;
   endtask

   task automatic check_outputs();
      logic [N-1:0] eg;
      logic [7:0]   eh;
      eg = m_scan ? (N'(1) << m_owner) : '0;
      eh = 8'hFF;
      if (m_scan) eh[7 - m_pos/SD] = 1'b0;
      check("grant", grant, eg);
      check("hang", hang, eh);
      check("gre", gre, m_gre);
      check("beep", beep, m_beep);
      check("frame_done", frame_done, m_scan && (m_pos == FRAME - 1));
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int len, idx;
      rst = 1'b1; req = '0; beep_req = '0;
      bitmap = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model_reset();
      #2;
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;

      // Idle with no requests.
      run(100);

      // Single requester: source 2 with a recognisable bitmap.
      for (int r = 0; r < 8; r++) bitmap[128 + 8*r +: 8] = 8'h10 + 8'(r);
      req = 3'b100;
      cycle();
      check("first_grant", grant, 3'b100);
      check("first_hang", hang, 8'h7F);
      check("first_gre", gre, 8'h10);
      run(FRAME + 20);

      // Source 0 requests mid-frame 1; owner 2 keeps the matrix until its 4th frame ends.
      req = 3'b101; beep_req = 3'b100;
      run(3*FRAME - 21);
      check("hold_grant", grant, 3'b100);
      check("hold_frame_done", frame_done, 1'b1);
      cycle();
      check("switch_grant", grant, 3'b001);
      check("switch_hang", hang, 8'h7F);
      check("switch_beep", beep, 1'b0);

      // Owner drops request at the end of row 2: blank rows 3..7, then idle.
      req = 3'b001; beep_req = 3'b000;
      run(3*SD - 1);
      req = 3'b000;
      run(5*SD);
      check("drop_gre", gre, 8'h00);
      check("drop_frame_done", frame_done, 1'b1);
      cycle();
      check("drop_idle_grant", grant, 3'b000);
      check("drop_idle_hang", hang, 8'hFF);

      // Beeper on source 1, then released.
      req = 3'b010; beep_req = 3'b010;
      run(60);
      beep_req = 3'b000;
      cycle();
      check("beep_release", beep, 1'b0);
      run(10);

      // Random traffic with bitmaps changing mid-frame.
      for (int blk = 0; blk < 40; blk++) begin
         req      = N'($urandom);
         beep_req = N'($urandom);
         len      = $urandom_range(1, 300);
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) begin
               idx = $urandom_range(0, 64*N - 1);
               bitmap[idx] = ~bitmap[idx];
            end
            cycle();
         end
      end

      // All sources requesting continuously.
      req = 3'b111; beep_req = 3'b111;
      run(13 * FRAME);

      // Asynchronous reset in the middle of a row.
      run(37);
      #3 rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      check("rst_hang", hang, 8'hFF);
      check("rst_grant", grant, 3'b000);
      #1 rst = 1'b0;
      run(3 * FRAME);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
